// File: rtl/bls_word_sub_seq_pkg.sv
// Shared definitions for the nibble-serial subtractor sequencer.
// Holds the FSM encoding, the slice width and an index-width helper.
package bls_word_sub_seq_pkg;

  localparam int SLICE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bls_word_sub_seq_slice.sv
// 4-bit borrow-lookahead subtractor: diff = x - y - bin.
// Purely combinational; all four internal borrows come from g/p terms.
module bls4_slice (
  output logic [3:0] diff,
  output logic       bout,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] br;

  always_comb begin
    // generate when x<y bitwise, propagate when equal
    g = ~x & y;
    p = ~(x ^ y);
    br[0] = bin;
    br[1] = g[0]
          | (p[0] & bin);
    br[2] = g[1]
          | (p[1] & g[0])
          | (p[1] & p[0] & bin);
    br[3] = g[2]
          | (p[2] & g[1])
          | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & bin);
    bout  = g[3]
          | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bin);
    diff  = x ^ y ^ br;
  end

endmodule

// File: rtl/bls_word_sub_seq.sv
// Word subtractor that reuses one 4-bit slice, one nibble per clock.
// start/done handshake; result held until the next accepted start.
module bls_word_sub_seq
  import bls_word_sub_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = SLICE_W * NIBBLES,
  localparam int IW      = idx_w(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         zero
);

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           borrow_q, borrow_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           bout_q, bout_d;
  logic           zero_q, zero_d;

  logic [SLICE_W-1:0] s_x;
  logic [SLICE_W-1:0] s_y;
  logic [SLICE_W-1:0] s_diff;
  logic               s_bout;
  logic [W-1:0]       diff_asm;
  logic               last;

  bls4_slice u_slice (
    .diff (s_diff),
    .bout (s_bout),
    .x    (s_x),
    .y    (s_y),
    .bin  (borrow_q)
  );

  assign last = (idx_q == IW'(NIBBLES - 1));

  // nibble select and write-back merge
  always_comb begin
    s_x      = '0;
    s_y      = '0;
    diff_asm = diff_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        s_x = a_q[i*SLICE_W +: SLICE_W];
        s_y = b_q[i*SLICE_W +: SLICE_W];
        diff_asm[i*SLICE_W +: SLICE_W] = s_diff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (last)  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          diff_d   = '0;
          bout_d   = 1'b0;
          zero_d   = 1'b0;
        end
      end
      S_RUN: begin
        diff_d   = diff_asm;
        borrow_d = s_bout;
        if (last) begin
          idx_d  = '0;
          bout_d = s_bout;
          zero_d = (diff_asm == '0);
        end else begin
          idx_d  = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_bls_word_sub_seq.sv
// Bench for bls_word_sub_seq: directed literal cases plus random ops
// checked every cycle against a latency/arithmetic reference model.
module tb_bls_word_sub_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, zero;
  logic [W-1:0] diff;

  logic         start1 = 1'b0;
  logic [3:0]   a1 = '0;
  logic [3:0]   b1 = '0;
  logic         bin1 = 1'b0;
  logic         busy1, done1, bout1, zero1;
  logic [3:0]   diff1;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bls_word_sub_seq #(.NIBBLES(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff),
    .bout(bout), .zero(zero)
  );

  bls_word_sub_seq #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1),
    .bout(bout1), .zero(zero1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: cycles elapsed since acceptance, result from plain math
  int           m_cnt = 0;
  logic [W-1:0] m_diff = '0, p_diff = '0;
  logic         m_bout = 1'b0, p_bout = 1'b0;
  logic         m_zero = 1'b0, p_zero = 1'b0;
  bit           m_valid = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_diff <= '0; m_bout <= 1'b0; m_zero <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_cnt == 0) begin
      if (start) begin
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        p_diff <= r[W-1:0];
        p_bout <= r[W];
        p_zero <= (r[W-1:0] == '0);
        m_valid <= 1'b0;
        m_cnt <= 1;
      end
    end else if (m_cnt == N + 1) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == N) begin
        m_diff <= p_diff; m_bout <= p_bout; m_zero <= p_zero;
        m_valid <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", 32'(busy), 32'(m_cnt >= 1 && m_cnt <= N));
      chk("m_done", 32'(done), 32'(m_cnt == N + 1));
      if (m_valid) begin
        chk("m_diff", 32'(diff), 32'(m_diff));
        chk("m_bout", 32'(bout), 32'(m_bout));
        chk("m_zero", 32'(zero), 32'(m_zero));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_, input logic tbin,
                        input logic [W-1:0] ed, input logic eb,
                        input logic ez);
    int k;
    int nb;
    step();
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    k = 1; nb = 0;
    while (!done && k < 20) begin
      if (busy) nb++;
      step();
      k++;
    end
    chk({nm, "_lat"}, 32'(k), 32'(N + 1));
    chk({nm, "_nbusy"}, 32'(nb), 32'(N));
    chk({nm, "_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_bout"}, 32'(bout), 32'(eb));
    chk({nm, "_zero"}, 32'(zero), 32'(ez));
    step();
    chk({nm, "_done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    int gap;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    run_op("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("t2", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    run_op("t3", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1);
    run_op("t4", 16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // ignored re-starts in RUN (cycle 2) and DONE (cycle 5)
    step();
    a = 16'h5555; b = 16'h1111; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 16'hFFFF; b = 16'h0000;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1; a = 16'h0F0F; b = 16'h7777; bin = 1'b1;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_diff", 32'(diff), 32'h4444);
    step();
    start = 1'b0;
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_done", 32'(done), 32'd0);
    chk("t5_hold", 32'(diff), 32'h4444);

    // reset in cycle 3 of a new op
    a = 16'h9999; b = 16'h1234; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #2;
    chk("t5r_busy", 32'(busy), 32'd0);
    chk("t5r_done", 32'(done), 32'd0);
    chk("t5r_diff", 32'(diff), 32'd0);
    chk("t5r_bout", 32'(bout), 32'd0);
    chk("t5r_zero", 32'(zero), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    gap = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) gap++;
      step();
    end
    chk("t5r_no_done", 32'(gap), 32'd0);

    // single-nibble instance
    a1 = 4'hD; b1 = 4'h5; bin1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0; a1 = 4'h0; b1 = 4'hF;
    chk("t6_busy1", 32'(busy1), 32'd1);
    chk("t6_done1_c1", 32'(done1), 32'd0);
    step();
    chk("t6_done1", 32'(done1), 32'd1);
    chk("t6_busy1_c2", 32'(busy1), 32'd0);
    chk("t6_diff1", 32'(diff1), 32'h8);
    chk("t6_bout1", 32'(bout1), 32'd0);
    chk("t6_zero1", 32'(zero1), 32'd0);

    // random ops with stray starts and input churn
    for (int n = 0; n < 80; n++) begin
      start = 1'b1;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      step();
      gap = $urandom_range(1, 9);
      for (int j = 0; j < gap; j++) begin
        start = ($urandom_range(0, 3) == 0);
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        step();
      end
    end
    start = 1'b0;
    repeat (N + 3) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
